// File: rtl/add_pkg.sv
// Shared types for the multi-byte add sequencer: byte width, FSM states
// and the packed ALU flag bundle.
package add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/multibyte_add_flags.sv
// Combinational C/Z/N/V flags from the most-significant byte of a
// chained add, given whether the lower result bytes were already zero.
import add_pkg::*;

module multibyte_add_flags (
  input  logic              a_msb,
  input  logic              b_eff_msb,
  input  logic [BYTE_W-1:0] add_sum,
  input  logic              add_cout,
  input  logic              upper_zero,
  output alu_flags_t        flags
);

  always_comb begin
    flags.c = add_cout;
    flags.z = upper_zero && (add_sum == '0);
    flags.n = add_sum[BYTE_W-1];
    // b_eff_msb is the already-inverted operand for subtract, so one rule
    // covers both add and subtract overflow.
    flags.v = (a_msb == b_eff_msb) && (add_sum[BYTE_W-1] != a_msb);
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// Sequences a wide add/subtract through an external 8-bit adder one byte
// per cycle (LSB first), then returns result and flags over valid/ready.
import add_pkg::*;

module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [8*NBYTES-1:0]      op_a,
  input  logic [8*NBYTES-1:0]      op_b,
  input  logic                     sub,
  input  logic                     carry_in,
  output logic [BYTE_W-1:0]        add_a,
  output logic [BYTE_W-1:0]        add_b,
  output logic                     add_cin,
  input  logic [BYTE_W-1:0]        add_sum,
  input  logic                     add_cout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [8*NBYTES-1:0]      result,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     flag_n,
  output logic                     flag_v
);

  // Handshakes: a transfer happens on a rising edge where valid && ready
  // are both high; valid never depends on ready, and ready is state-only
  // (start_ready is additionally forced low while rst is high).

  localparam int W        = BYTE_W * NBYTES;
  localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     result_reg;
  alu_flags_t       flags_reg;
  alu_flags_t       flags_next;
  logic             upper_zero;
  logic             last_byte;

  assign last_byte = (idx == LAST_IDX);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = !rst;
        if (start_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_byte) begin
          state_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte lane select towards the external adder; quiet outside RUN.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_cin = carry_reg;
      for (int i = 0; i < NBYTES; i++) begin
        if (idx == IDX_W'(i)) begin
          add_a = a_reg[i*BYTE_W +: BYTE_W];
          add_b = b_reg[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // All bytes below the one currently on the adder are already in result_reg.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NBYTES - 1; i++) begin
      if (result_reg[i*BYTE_W +: BYTE_W] != '0) begin
        upper_zero = 1'b0;
      end
    end
  end

  multibyte_add_flags u_flags (
    .a_msb      (a_reg[W-1]),
    .b_eff_msb  (b_reg[W-1]),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .upper_zero (upper_zero),
    .flags      (flags_next)
  );

  // Operand capture, byte collection and flag registration
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry_reg  <= 1'b0;
      idx        <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= sub ? ~carry_in : carry_in;
            idx       <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDX_W'(i)) begin
              result_reg[i*BYTE_W +: BYTE_W] <= add_sum;
            end
          end
          carry_reg <= add_cout;
          if (last_byte) begin
            flags_reg <= flags_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = result_reg;
  assign flag_c = flags_reg.c;
  assign flag_z = flags_reg.z;
  assign flag_n = flags_reg.n;
  assign flag_v = flags_reg.v;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq with a behavioural 8-bit adder
// standing in for the prefix adder next to the sequencer.
module tb_multibyte_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         carry_in;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         flag_c;
  logic         flag_z;
  logic         flag_n;
  logic         flag_v;

  int total;
  int bad;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .carry_in    (carry_in),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_v      (flag_v)
  );

  function automatic logic [3:0] flags4();
    return {flag_c, flag_z, flag_n, flag_v};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present a request, return at the negedge just after the accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic ci);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; carry_in = ci; start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) check("accept_timeout", 64'(start_ready), 64'd1);
    @(negedge clk);
    start_valid = 1'b0;
    op_a = $urandom; op_b = $urandom;
    sub = 1'($urandom_range(0, 1)); carry_in = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) check("result_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic take(input string tag, input logic [W-1:0] er, input logic [3:0] ef);
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_flags"}, 64'(flags4()), 64'(ef));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_rv_drop"}, 64'(res_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(start_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    int cyc;
    int acc_q[$];
    logic [W-1:0] held;

    total = 0; bad = 0;
    rst = 1'b1; start_valid = 1'b0; op_a = '0; op_b = '0;
    sub = 1'b0; carry_in = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_ready", 64'(start_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags4()), 64'd0);
    check("rst_add_bus", 64'({add_a, add_b, add_cin}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_start_ready", 64'(start_ready), 64'd1);

    // 1: carry ripples from byte 0 into byte 1; latency NBYTES
    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    check("t1_byte0_a", 64'(add_a), 64'hFF);
    check("t1_start_ready_run", 64'(start_ready), 64'd0);
    wait_result(lat);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_add_bus_done", 64'({add_a, add_b, add_cin}), 64'd0);
    take("t1", 32'h00000100, 4'b0000);

    // 2: wrap to zero
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_result(lat);
    take("t2", 32'h00000000, 4'b1100);

    // 3: signed overflow, then carry-in on add
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_result(lat);
    take("t3a", 32'h80000000, 4'b0011);
    send(32'h12345678, 32'h11111111, 1'b0, 1'b1);
    wait_result(lat);
    take("t3b", 32'h2345678A, 4'b0000);

    // 4: subtract with borrow, overflow, and borrow-in
    send(32'h00000005, 32'h00000007, 1'b1, 1'b0);
    check("t4a_byte0_b", 64'(add_b), 64'hF8);
    check("t4a_byte0_cin", 64'(add_cin), 64'd1);
    wait_result(lat);
    take("t4a", 32'hFFFFFFFE, 4'b0010);
    send(32'h80000000, 32'h00000001, 1'b1, 1'b0);
    wait_result(lat);
    take("t4b", 32'h7FFFFFFF, 4'b1001);
    send(32'h00000010, 32'h00000005, 1'b1, 1'b1);
    wait_result(lat);
    take("t4c", 32'h0000000A, 4'b1000);

    // 5: backpressure in DONE with ignored start pulses
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    wait_result(lat);
    held = result;
    check("t5_held_value", 64'(held), 64'h00010000);
    for (int i = 0; i < 3; i++) begin
      start_valid = 1'(i % 2 == 0);
      op_a = 32'hDEAD0000; op_b = 32'h0000BEEF;
      @(negedge clk);
      check("t5_bp_valid", 64'(res_valid), 64'd1);
      check("t5_bp_ready", 64'(start_ready), 64'd0);
      check("t5_bp_result", 64'(result), 64'(held));
      check("t5_bp_flags", 64'(flags4()), 64'b0000);
    end
    start_valid = 1'b0;
    take("t5", 32'h00010000, 4'b0000);
    @(negedge clk);
    check("t5_no_stray_run", 64'(res_valid), 64'd0);

    // 5b: back-to-back with both sides always ready
    res_ready = 1'b1;
    op_a = 32'h00000001; op_b = 32'h00000002; sub = 1'b0; carry_in = 1'b0;
    start_valid = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (start_ready && start_valid) acc_q.push_back(cyc);
      @(negedge clk);
    end
    start_valid = 1'b0;
    check("t5b_accepts", 64'(acc_q.size() >= 3), 64'd1);
    if (acc_q.size() >= 3) begin
      check("t5b_gap1", 64'(acc_q[1] - acc_q[0]), 64'd6);
      check("t5b_gap2", 64'(acc_q[2] - acc_q[1]), 64'd6);
    end
    repeat (8) @(negedge clk);
    res_ready = 1'b0;
    check("t5b_result", 64'(result), 64'h00000003);
    check("t5b_idle", 64'(start_ready), 64'd1);

    // 6: reset while idx==2
    send(32'h44332211, 32'h01010101, 1'b0, 1'b0);
    check("t6_byte0_a", 64'(add_a), 64'h11);
    @(negedge clk);
    @(negedge clk);
    check("t6_byte2_a", 64'(add_a), 64'h33);
    check("t6_byte2_b", 64'(add_b), 64'h01);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 64'(res_valid), 64'd0);
    check("t6_rst_result", 64'(result), 64'd0);
    check("t6_rst_flags", 64'(flags4()), 64'd0);
    check("t6_rst_add_bus", 64'({add_a, add_b, add_cin}), 64'd0);
    check("t6_rst_ready", 64'(start_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_ready", 64'(start_ready), 64'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) pulses++;
      @(negedge clk);
    end
    check("t6_no_pulse", 64'(pulses), 64'd0);
    send(32'h00000001, 32'h00000001, 1'b0, 1'b0);
    wait_result(lat);
    check("t6_latency", 64'(lat), 64'd4);
    take("t6", 32'h00000002, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Multi-cycle sequencer placed directly upstream of the 8-bit prefix adder.
- Accepts a wide add/subtract request and feeds the adder one byte per cycle, least-significant byte first, chaining each byte's carry-out into the next byte's carry-in.
- Collects the sum bytes and computes C/Z/N/V flags.
- Returns the result over a valid/ready handshake.

Parameters:
- NBYTES, 4, operand width in bytes (≥1); data width W = 8*NBYTES.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  request valid.
- start_ready  output  1  request accepted when start_valid && start_ready.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- sub  input  1  0 = A+B+carry_in; 1 = A−B−carry_in (carry_in acts as borrow).
- carry_in  input  1  initial carry/borrow.
- add_a  output  8  byte to adder A.
- add_b  output  8  byte to adder B (already inverted for subtract).
- add_cin  output  1  adder carry-in.
- add_sum  input  8  adder Sum, combinational same cycle.
- add_cout  input  1  adder Cout, combinational same cycle.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer ready.
- result  output  W  final sum/difference.
- flag_c  output  1  carry-out of MSB byte (subtract: 1 = no borrow).
- flag_z  output  1  result == 0.
- flag_n  output  1  result[W-1].
- flag_v  output  1  signed overflow.

Behaviour:
- Reset: state=IDLE; result, flags, res_valid, add_a, add_b, add_cin all 0; byte index 0; start_ready=0 while rst high.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On accept, register:
    - a_reg = op_a;
    - b_reg = sub ? ~op_b : op_b;
    - carry_reg = sub ? ~carry_in : carry_in;
    - idx = 0.
  - Next state RUN.
- RUN:
  - start_ready = 0.
  - Drive add_a = a_reg byte idx, add_b = b_reg byte idx, add_cin = carry_reg.
  - At the clock edge: result byte idx ← add_sum; carry_reg ← add_cout; idx++.
  - When idx == NBYTES−1 at the edge: go to DONE and register flags:
    - flag_c = add_cout;
    - flag_n = add_sum[7];
    - flag_z = (upper result bytes == 0) && (add_sum == 0);
    - flag_v = (a_msb == b_eff_msb) && (add_sum[7] != a_msb).
- DONE:
  - res_valid = 1; result and flags held stable.
  - add_* outputs = 0.
  - On res_valid && res_ready: go to IDLE, res_valid=0 next cycle.
  - No same-cycle restart; start_ready returns the following cycle.
- Latency: res_valid rises exactly NBYTES cycles after the accept edge. Throughput is one operation per NBYTES+2 cycles with res_ready held high.
- add_* outputs are 0 in IDLE and DONE.
- Operands are sampled only on accept; changes to op_a/op_b afterwards are ignored.
- start_valid during RUN/DONE is ignored (not accepted).
- NBYTES=1: RUN lasts a single cycle.
- rst mid-RUN or mid-DONE: operation aborted, state=IDLE next cycle, no res_valid pulse, all outputs 0.
- idx counter width is clog2(NBYTES), minimum 1 bit; it never wraps past NBYTES−1.

Decomposition:
- Shared package add_pkg:
  - BYTE_W = 8;
  - state enum {IDLE, RUN, DONE};
  - packed struct alu_flags_t {c, z, n, v}.
- One natural sub-module, multibyte_add_flags: combinational MSB-byte flag computation (inputs: a_msb, b_eff_msb, add_sum, add_cout, upper-zero; output: alu_flags_t).
- The 8-bit prefix adder is instantiated beside this block at the next level up, not inside it.

Test Plan:
1. NBYTES=4, add, op_a=0x000000FF, op_b=0x00000001, carry_in=0 -> result=0x00000100; C=0, Z=0, N=0, V=0; res_valid exactly 4 cycles after accept.
2. add 0xFFFFFFFF + 0x00000001, carry_in=0 -> result=0x00000000; C=1, Z=1, N=0, V=0.
3. add 0x7FFFFFFF + 0x00000001 -> result=0x80000000; V=1, N=1, C=0, Z=0. Also add 0x12345678 + 0x11111111, carry_in=1 -> result=0x2345678A.
4. sub 0x00000005 − 0x00000007, carry_in=0 -> result=0xFFFFFFFE; C=0, N=1, V=0. Also sub 0x80000000 − 0x00000001 -> result=0x7FFFFFFF; V=1, C=1.
5. Backpressure: hold res_ready=0 for 3 cycles in DONE -> result/flags stable, start_ready=0, start_valid pulses ignored. Then res_ready=1 -> handshake, res_valid=0 and start_ready=1 next cycle. Back-to-back requests -> each accepted NBYTES+2 cycles apart.
6. Assert rst for 1 cycle while idx=2 in RUN -> next cycle IDLE, res_valid never pulses, result=0, flags=0. A fresh request then completes correctly (e.g. 1+1 -> 0x00000002).
